// File: rtl/snn_sched_pkg.sv
// Shared types and width helpers for the SNN inference-window scheduler.
package snn_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bits needed to index n items (0..n-1); never less than 1.
    function automatic int index_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the value v itself; never less than 1.
    function automatic int value_w(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// One saturating spike counter: clear wins over inc, and the count sticks at all-ones.
module snn_spike_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count != '1)) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/snn_window_scheduler.sv
// Sequences one SNN inference window and returns the argmax neuron over valid/ready.
// Optional feature macro: SNN_EARLY_STOP_EN (stop RUN once any count reaches EARLY_CNT).
module snn_window_scheduler
    import snn_sched_pkg::*;
#(
    parameter int N_NEURON    = 4,
    parameter int T_WINDOW    = 250,
    parameter int ENCODE_TIME = 23,
    parameter int STEP_DIV    = 50,
    parameter int CNT_W       = 8,
    parameter int EARLY_CNT   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_NEURON-1:0]         spikes,
    output logic                        busy,
    output logic                        neuron_rst,
    output logic                        neuron_en,
    output logic                        enc_phase,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [$clog2(N_NEURON)-1:0] winner_idx,
    output logic [CNT_W-1:0]            winner_cnt,
    output logic                        no_spike,
    output state_t                      fsm_state
);

    localparam int IDX_W  = $clog2(N_NEURON);
    localparam int DIV_W  = index_w(STEP_DIV);
    localparam int STEP_W = value_w(T_WINDOW);

`ifdef SNN_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_next;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   best_idx;
    logic [CNT_W-1:0]   best_cnt;
    logic [IDX_W-1:0]   eval_idx;
    logic [CNT_W-1:0]   eval_cnt;
    logic [CNT_W-1:0]   cnt      [N_NEURON];
    logic [CNT_W-1:0]   cnt_next [N_NEURON];
    logic               sample;
    logic               clear_cnt;
    logic               last_div;
    logic               last_step;
    logic               hit;
    logic               early_stop;

    assign fsm_state = state;

    // Spikes are taken one cycle after the enable pulse, when the array output has settled.
    assign sample    = (state == RUN) && (div == DIV_W'(1));
    assign clear_cnt = (state == CLEAR);
    assign last_div  = (div == DIV_W'(STEP_DIV - 1));
    assign last_step = (step == STEP_W'(T_WINDOW - 1));
    assign step_next = step + 1'b1;

    for (genvar g = 0; g < N_NEURON; g++) begin : g_cnt
        snn_spike_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear_cnt),
            .inc        (sample && spikes[g]),
            .count      (cnt[g]),
            .count_next (cnt_next[g])
        );
    end

    // Threshold is judged on the counts as they will be after this sample lands.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_NEURON; i++) begin
            if (int'(cnt_next[i]) >= EARLY_CNT) begin
                hit = 1'b1;
            end
        end
    end

    assign early_stop = EARLY_STOP && sample && hit;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        eval_idx = best_idx;
        eval_cnt = best_cnt;
        if (cnt[scan_idx] > best_cnt) begin
            eval_idx = scan_idx;
            eval_cnt = cnt[scan_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div          <= '0;
            step         <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            busy         <= 1'b0;
            neuron_rst   <= 1'b0;
            neuron_en    <= 1'b0;
            enc_phase    <= 1'b0;
            result_valid <= 1'b0;
            winner_idx   <= '0;
            winner_cnt   <= '0;
            no_spike     <= 1'b0;
        end else begin
            neuron_rst <= 1'b0;
            neuron_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        neuron_rst <= 1'b1;
                    end
                end
                CLEAR: begin
                    state     <= RUN;
                    div       <= '0;
                    step      <= '0;
                    neuron_en <= 1'b1;
                    enc_phase <= (ENCODE_TIME > 0);
                end
                RUN: begin
                    if (early_stop || (last_div && last_step)) begin
                        state     <= EVAL;
                        enc_phase <= 1'b0;
                        div       <= '0;
                        step      <= '0;
                        scan_idx  <= '0;
                        best_idx  <= '0;
                        best_cnt  <= '0;
                    end else if (last_div) begin
                        div       <= '0;
                        step      <= step_next;
                        neuron_en <= 1'b1;
                        enc_phase <= (step_next < STEP_W'(ENCODE_TIME));
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                EVAL: begin
                    best_idx <= eval_idx;
                    best_cnt <= eval_cnt;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == IDX_W'(N_NEURON - 1)) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        winner_idx   <= eval_idx;
                        winner_cnt   <= eval_cnt;
                        no_spike     <= (eval_cnt == '0);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
